// File: rtl/whack_judge_pkg.sv
// whack_judge_pkg: shared game constants, judge state encoding and helpers
package whack_judge_pkg;
  localparam int N_HOLES_DEFAULT = 18;
  localparam int CLK_HZ = 50_000_000;
  localparam int HOLE_IDX_W = 5;
  typedef enum logic [1:0] {IDLE, EMIT, LOCKOUT} judge_state_e;
  function automatic int cnt_w(input int p);
    return $clog2(p < 2 ? 2 : p);
  endfunction
  function automatic logic [HOLE_IDX_W-1:0] lowest_idx(input logic [31:0] v);
    lowest_idx = '0;
    for (int i = 31; i >= 0; i--)
      if (v[i]) lowest_idx = HOLE_IDX_W'(i);
  endfunction
endpackage

// File: rtl/whack_judge_debounce.sv
// switch_debounce: 2-flop synchroniser, shared debounce counter, stable vector and strike pulses
module switch_debounce
  import whack_judge_pkg::*;
#(
  parameter int N = N_HOLES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] switches,
  output logic [N-1:0] strike_vec
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  logic [N-1:0] meta, sync_sw, last_sw, stable;
  logic [CW-1:0] cnt;
  logic settled;
  assign settled = sync_sw == last_sw && cnt == CW'(DEBOUNCE_CYCLES - 1);
  // synchroniser is never reset so stable can reload the live switch value during reset
  always_ff @(posedge clk) begin
    meta <= switches;
    sync_sw <= meta;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= sync_sw;
      last_sw <= sync_sw;
      cnt <= '0;
      strike_vec <= '0;
    end else begin
      last_sw <= sync_sw;
      cnt <= sync_sw != last_sw ? '0 : settled ? cnt : cnt + 1'b1;
      strike_vec <= settled ? sync_sw ^ stable : '0;
      if (settled) stable <= sync_sw;
    end
  end
endmodule

// File: rtl/whack_judge.sv
// whack_judge: judges debounced switch strikes against the mole mask and emits hit/miss events
module whack_judge
  import whack_judge_pkg::*;
#(
  parameter int N_HOLES = N_HOLES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LOCKOUT_CYCLES = 2_500_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  game_active,
  input  logic [N_HOLES-1:0]    switches,
  input  logic [N_HOLES-1:0]    mole_mask,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic                  evt_hit,
  output logic [HOLE_IDX_W-1:0] evt_hole,
  output logic [N_HOLES-1:0]    mole_clear,
  output logic                  busy
);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_EMIT = EMIT;
  localparam logic [1:0] S_LOCK = LOCKOUT;
  localparam int LW = cnt_w(LOCKOUT_CYCLES);
  if (N_HOLES > 32 || N_HOLES < 1) begin : g_width_chk
    $error("whack_judge: N_HOLES must be 1..32");
  end
  logic [N_HOLES-1:0] strike_vec, pending, sel_clear;
  logic [1:0] state;
  logic [LW-1:0] lock_cnt;
  logic [HOLE_IDX_W-1:0] sel;
  logic go;
  switch_debounce #(.N(N_HOLES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk),
    .rst(rst),
    .switches(switches),
    .strike_vec(strike_vec)
  );
  assign sel = lowest_idx(32'(pending));
  assign go = state == S_IDLE && game_active && |pending;
  assign sel_clear = go ? N_HOLES'(1) << sel : '0;
  assign busy = state != S_IDLE || |pending;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pending <= '0;
      lock_cnt <= '0;
      evt_valid <= 1'b0;
      evt_hit <= 1'b0;
      evt_hole <= '0;
      mole_clear <= '0;
    end else begin
      pending <= game_active ? (pending | strike_vec) & ~sel_clear : '0;
      mole_clear <= '0;
      if (state == S_IDLE) begin
        if (go) begin
          evt_hole <= sel;
          evt_hit <= mole_mask[sel];
          evt_valid <= 1'b1;
          state <= S_EMIT;
        end
      end else if (state == S_EMIT) begin
        if (evt_ready) begin
          evt_valid <= 1'b0;
          mole_clear <= evt_hit ? N_HOLES'(1) << evt_hole : '0;
          lock_cnt <= '0;
          state <= LOCKOUT_CYCLES == 0 ? S_IDLE : S_LOCK;
        end
      end else begin
        lock_cnt <= lock_cnt + 1'b1;
        if (lock_cnt == LW'(LOCKOUT_CYCLES - 1)) state <= S_IDLE;
      end
    end
  end
endmodule
